// File: rtl/fpu_issue_pkg.sv
// Shared types, default widths and the one-hot helper for the FPU issue controller.
package fpu_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } fpu_issue_state_t;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_CTRL_W    = 8;
    localparam int DEF_NUM_UNITS = 10;
    localparam int MAX_UNITS     = 64;
    localparam int MAX_UNIT_W    = 6;

    // Callers size-cast the result down to their own unit count.
    function automatic logic [MAX_UNITS-1:0] onehot(input logic [MAX_UNIT_W-1:0] idx);
        logic [MAX_UNITS-1:0] vec;
        vec      = {MAX_UNITS{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/fpu_watchdog.sv
// Clearable WAIT-cycle counter; flags expiry when the count reaches TIMEOUT-1.
module fpu_watchdog
#(
    parameter int TIMEOUT = 255
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_r;

    // Count cycles spent waiting; restart on every new issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = en && (cnt_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding issue controller between the core and a bank of FPU units.
// Optional watchdog timeout is built when FPU_ISSUE_TIMEOUT_EN is defined.
module fpu_issue_ctrl
    import fpu_issue_pkg::*;
#(
    parameter int NUM_UNITS = DEF_NUM_UNITS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CTRL_W    = DEF_CTRL_W,
    parameter int TIMEOUT   = 255,
    parameter int UNIT_W    = $clog2(NUM_UNITS)
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [UNIT_W-1:0]    req_unit,
    input  logic [DATA_W-1:0]    req_a,
    input  logic [DATA_W-1:0]    req_b,
    input  logic [CTRL_W-1:0]    req_c,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_data,
    output logic                 rsp_err,
    output logic [DATA_W-1:0]    fpu_data_a,
    output logic [DATA_W-1:0]    fpu_data_b,
    output logic [CTRL_W-1:0]    fpu_data_c,
    output logic [NUM_UNITS-1:0] fpu_in_valid,
    input  logic [DATA_W-1:0]    fpu_out,
    input  logic                 fpu_out_valid
);

    fpu_issue_state_t     state_r, state_d;
    logic [DATA_W-1:0]    data_a_r, data_a_d, data_b_r, data_b_d;
    logic [CTRL_W-1:0]    data_c_r, data_c_d;
    logic [NUM_UNITS-1:0] in_valid_r, in_valid_d;
    logic                 rsp_valid_r, rsp_valid_d, rsp_err_r, rsp_err_d;
    logic [DATA_W-1:0]    rsp_data_r, rsp_data_d;
    logic                 unit_ok_s, expired_s;

`ifdef FPU_ISSUE_TIMEOUT_EN
    fpu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_r == ST_ISSUE),
        .en      (state_r == ST_WAIT),
        .expired (expired_s)
    );
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^32'(TIMEOUT);
    assign expired_s        = 1'b0;
`endif

    assign unit_ok_s = ({1'b0, req_unit} < (UNIT_W + 1)'(NUM_UNITS));

    // Next-state and next-output decode for the issue FSM.
    always_comb begin
        state_d     = state_r;
        data_a_d    = data_a_r;
        data_b_d    = data_b_r;
        data_c_d    = data_c_r;
        in_valid_d  = {NUM_UNITS{1'b0}};
        rsp_valid_d = rsp_valid_r;
        rsp_err_d   = rsp_err_r;
        rsp_data_d  = rsp_data_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    data_a_d = req_a;
                    data_b_d = req_b;
                    data_c_d = req_c;
                    if (unit_ok_s) begin
                        // Strobe is registered here so it is visible in the ISSUE cycle.
                        in_valid_d = NUM_UNITS'(onehot(MAX_UNIT_W'(req_unit)));
                        state_d    = ST_ISSUE;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = {DATA_W{1'b0}};
                        state_d     = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the expiry cycle takes priority.
                if (fpu_out_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = fpu_out;
                    state_d     = ST_RESP;
                end else if (expired_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = {DATA_W{1'b0}};
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered-output storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            data_a_r    <= {DATA_W{1'b0}};
            data_b_r    <= {DATA_W{1'b0}};
            data_c_r    <= {CTRL_W{1'b0}};
            in_valid_r  <= {NUM_UNITS{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_d;
            data_a_r    <= data_a_d;
            data_b_r    <= data_b_d;
            data_c_r    <= data_c_d;
            in_valid_r  <= in_valid_d;
            rsp_valid_r <= rsp_valid_d;
            rsp_err_r   <= rsp_err_d;
            rsp_data_r  <= rsp_data_d;
        end
    end

    assign req_ready    = (state_r == ST_IDLE);
    assign rsp_valid    = rsp_valid_r;
    assign rsp_err      = rsp_err_r;
    assign rsp_data     = rsp_data_r;
    assign fpu_data_a   = data_a_r;
    assign fpu_data_b   = data_b_r;
    assign fpu_data_c   = data_c_r;
    assign fpu_in_valid = in_valid_r;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl; the timeout scenario adapts to FPU_ISSUE_TIMEOUT_EN.
module tb_fpu_issue_ctrl;

    localparam int NU = 10;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int TO = 4;
    localparam int UW = $clog2(NU);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [UW-1:0] req_unit = '0;
    logic [DW-1:0] req_a = '0, req_b = '0;
    logic [CW-1:0] req_c = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [DW-1:0] fpu_data_a, fpu_data_b;
    logic [CW-1:0] fpu_data_c;
    logic [NU-1:0] fpu_in_valid;
    logic [DW-1:0] fpu_out = '0;
    logic          fpu_out_valid = 1'b0;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fpu_issue_ctrl #(.NUM_UNITS(NU), .DATA_W(DW), .CTRL_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_unit(req_unit),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fpu_data_a(fpu_data_a), .fpu_data_b(fpu_data_b), .fpu_data_c(fpu_data_c),
        .fpu_in_valid(fpu_in_valid), .fpu_out(fpu_out), .fpu_out_valid(fpu_out_valid)
    );

    always #5 clk = ~clk;

    // Advance one cycle; any handshake seen at the falling edge is scored against the queue.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: got err=%0b data=%h, expected no response", rsp_err, rsp_data);
            end else begin
                e = exp_q.pop_front();
                if (rsp_err !== e.err || rsp_data !== e.data) begin
                    errors++;
                    $display("FAIL scoreboard_rsp: got err=%0b data=%h, expected err=%0b data=%h",
                             rsp_err, rsp_data, e.err, e.data);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 32'h0 ||
            fpu_data_a !== 32'h0 || fpu_data_b !== 32'h0 || fpu_data_c !== 8'h0 || fpu_in_valid !== 10'h0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%0b vld=%0b err=%0b data=%h a=%h b=%h c=%h iv=%h, expected 1 0 0 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_data, fpu_data_a, fpu_data_b, fpu_data_c, fpu_in_valid);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_normal_op();
        req_unit = 4'd3; req_a = 32'h3F800000; req_b = 32'h40000000; req_c = 8'h01;
        req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL normal_ready: got %0b, expected 1", req_ready); end
        step();
        req_valid = 1'b0;
        exp_q.push_back('{err: 1'b0, data: 32'h40400000});
        checks++;
        if (fpu_in_valid !== 10'h008) begin errors++; $display("FAIL normal_strobe: got %h, expected 008", fpu_in_valid); end
        checks++;
        if (fpu_data_a !== 32'h3F800000 || fpu_data_b !== 32'h40000000 || fpu_data_c !== 8'h01) begin
            errors++;
            $display("FAIL normal_operands: got %h %h %h, expected 3f800000 40000000 01", fpu_data_a, fpu_data_b, fpu_data_c);
        end
        step();
        checks++;
        if (fpu_in_valid !== 10'h000) begin errors++; $display("FAIL normal_strobe_drop: got %h, expected 000", fpu_in_valid); end
        step();
        step();
        fpu_out = 32'h40400000; fpu_out_valid = 1'b1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL normal_early_rsp: got %0b, expected 0", rsp_valid); end
        step();
        fpu_out_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h40400000 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL normal_rsp: got vld=%0b data=%h err=%0b, expected 1 40400000 0", rsp_valid, rsp_data, rsp_err);
        end
        step();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL normal_idle: got rdy=%0b vld=%0b, expected 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_bad_unit();
        req_unit = 4'd12; req_a = 32'hDEADBEEF; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        exp_q.push_back('{err: 1'b1, data: 32'h0});
        checks++;
        if (fpu_in_valid !== 10'h000) begin errors++; $display("FAIL bad_unit_strobe: got %h, expected 000", fpu_in_valid); end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0 || fpu_data_a !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bad_unit_rsp: got vld=%0b err=%0b data=%h a=%h, expected 1 1 0 deadbeef",
                     rsp_valid, rsp_err, rsp_data, fpu_data_a);
        end
        step();
    endtask

    task automatic test_back_pressure();
        rsp_ready = 1'b0;
        req_unit = 4'd9; req_a = 32'h1; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        exp_q.push_back('{err: 1'b0, data: 32'hCAFE0009});
        checks++;
        if (fpu_in_valid !== 10'h200) begin errors++; $display("FAIL bp_strobe: got %h, expected 200", fpu_in_valid); end
        step();
        fpu_out = 32'hCAFE0009; fpu_out_valid = 1'b1;
        step();
        fpu_out_valid = 1'b0; fpu_out = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFE0009 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got vld=%0b data=%h rdy=%0b, expected 1 cafe0009 0", i, rsp_valid, rsp_data, req_ready);
            end
            step();
        end
        rsp_ready = 1'b1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_release_ready: got %0b, expected 0", req_ready); end
        step();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: got rdy=%0b vld=%0b, expected 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_timeout();
        req_unit = 4'd0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
        exp_q.push_back('{err: 1'b1, data: 32'h0});
        for (int i = 0; i < TO; i++) step();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL timeout_early: got %0b, expected 0", rsp_valid); end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL timeout_rsp: got vld=%0b err=%0b data=%h, expected 1 1 0", rsp_valid, rsp_err, rsp_data);
        end
        step();
        fpu_out = 32'h12345678; fpu_out_valid = 1'b1;
        step();
        fpu_out_valid = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL timeout_late_ignored: got %0b, expected 0", rsp_valid); end
`else
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL no_watchdog_wait: got %0b, expected 0", rsp_valid); end
        exp_q.push_back('{err: 1'b0, data: 32'h12345678});
        fpu_out = 32'h12345678; fpu_out_valid = 1'b1;
        step();
        fpu_out_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL no_watchdog_rsp: got vld=%0b err=%0b, expected 1 0", rsp_valid, rsp_err);
        end
        step();
`endif
    endtask

    task automatic test_simultaneous();
        req_unit = 4'd5; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        exp_q.push_back('{err: 1'b0, data: 32'hA5A5_0005});
        for (int i = 0; i < TO; i++) step();
        fpu_out = 32'hA5A5_0005; fpu_out_valid = 1'b1;
        step();
        fpu_out_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'hA5A5_0005) begin
            errors++;
            $display("FAIL simult_rsp: got vld=%0b err=%0b data=%h, expected 1 0 a5a50005", rsp_valid, rsp_err, rsp_data);
        end
        step();
        fpu_out = 32'hFFFF_0000; fpu_out_valid = 1'b1;
        step();
        fpu_out_valid = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_stray: got vld=%0b rdy=%0b, expected 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_wait();
        req_unit = 4'd7; req_a = 32'h55; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 32'h0 ||
            fpu_data_a !== 32'h0 || fpu_in_valid !== 10'h0) begin
            errors++;
            $display("FAIL reset_mid_wait: got rdy=%0b vld=%0b err=%0b data=%h a=%h iv=%h, expected 1 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_data, fpu_data_a, fpu_in_valid);
        end
        step();
        rst_n = 1'b1;
        fpu_out = 32'hBAD0BAD0; fpu_out_valid = 1'b1;
        step();
        fpu_out_valid = 1'b0;
        step();
        req_unit = 4'd1; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        exp_q.push_back('{err: 1'b0, data: 32'h0000_1111});
        checks++;
        if (fpu_in_valid !== 10'h002) begin errors++; $display("FAIL post_reset_strobe: got %h, expected 002", fpu_in_valid); end
        step();
        fpu_out = 32'h0000_1111; fpu_out_valid = 1'b1;
        step();
        fpu_out_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_1111 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_rsp: got vld=%0b data=%h err=%0b, expected 1 00001111 0", rsp_valid, rsp_data, rsp_err);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_normal_op();
        test_bad_unit();
        test_back_pressure();
        test_timeout();
        test_simultaneous();
        test_reset_mid_wait();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Parametrised single-outstanding issue controller between the CPU core and a bank of FPU units. It is the next generation of the flat FPU port on the core top: it supports configurable unit count and data width, registered operand/one-hot strobe generation, result capture with a ready/valid response, and an optional watchdog timeout. It sits inside the core top, between the execute stage and the external `fpu_data_a/b/c`, `fpu_in_valid`, `fpu_out`, `fpu_out_valid` pins.

## Interface
- `NUM_UNITS`, 10: number of FPU units; width of the `fpu_in_valid` one-hot.
- `DATA_W`, 32: operand/result width.
- `CTRL_W`, 8: width of the `c` control operand (rounding/mode).
- `TIMEOUT`, 255: watchdog limit in cycles; must be ≥2.
- `UNIT_W`, $clog2(NUM_UNITS): derived; not overridden.

- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core presents an operation.
- `req_ready` out 1: controller accepts an operation this cycle.
- `req_unit` in UNIT_W: target unit index.
- `req_a`, `req_b` in DATA_W: operands.
- `req_c` in CTRL_W: control operand.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: core consumes the result.
- `rsp_data` out DATA_W: result word.
- `rsp_err` out 1: result invalid (bad unit or timeout).
- `fpu_data_a`, `fpu_data_b` out DATA_W: registered operands to the FPU.
- `fpu_data_c` out CTRL_W: registered control operand.
- `fpu_in_valid` out NUM_UNITS: one-hot start strobe.
- `fpu_out` in DATA_W: FPU result.
- `fpu_out_valid` in 1: FPU result strobe.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch operands into `fpu_data_*`. If `req_unit` < NUM_UNITS go to ISSUE; otherwise load `rsp_err`=1, `rsp_data`=0 and go to RESP, with no strobe.
- ISSUE (one cycle): `fpu_in_valid` = one-hot of the latched unit. Next state is WAIT and the watchdog clears.
- WAIT: `fpu_in_valid`=0. On `fpu_out_valid`: capture `fpu_out` into `rsp_data`, set `rsp_err`=0, and go to RESP. On watchdog expiry: set `rsp_data`=0, `rsp_err`=1, and go to RESP.
- If `fpu_out_valid` and watchdog expiry occur in the same cycle, the result wins (`rsp_err`=0).
- RESP: `rsp_valid`=1. `rsp_data` and `rsp_err` stay stable until `rsp_ready`, then the controller returns to IDLE. `req_ready`=0, so there is no back-to-back acceptance in the RESP→IDLE cycle.
- `fpu_out_valid` outside WAIT is ignored. A stray or late result after a timeout is dropped.
- `fpu_data_*` hold their last value until the next accept.
- Reset mid-operation returns to IDLE immediately. Any in-flight FPU result is subsequently ignored.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0, `fpu_data_a/b/c`=0, `fpu_in_valid`=0.
- All outputs are registered except `req_ready`, which is decoded from state.
- Accept in cycle 0 → `fpu_in_valid` high in cycle 1 only.
- `fpu_out_valid` in cycle k ≥ 2 → `rsp_valid` in cycle k+1.
- The FPU latency minimum is 1 cycle after the strobe.
- Bad-unit accept in cycle 0 → `rsp_valid` with `rsp_err`=1 in cycle 1.
- The watchdog counts WAIT cycles from 0; expiry is when count == TIMEOUT-1. A timeout response therefore appears TIMEOUT+2 cycles after accept.
- Throughput: at most one operation per (latency + 3) cycles.

## Configuration
- Macro: `FPU_ISSUE_TIMEOUT_EN`.
- Defined: the watchdog is built and the timeout path operates as above.
- Undefined: there is no counter and WAIT waits indefinitely for `fpu_out_valid`. `rsp_err` is set only by bad-unit requests, and `TIMEOUT` is ignored.

## Structure
- Package `fpu_issue_pkg` holds:
  - the state enum `fpu_issue_state_t` (IDLE/ISSUE/WAIT/RESP);
  - the default localparams for DATA_W, CTRL_W and NUM_UNITS;
  - a `onehot` function that maps an index to a NUM_UNITS vector.
- Sub-module `fpu_watchdog`:
  - holds the clearable up-counter and the expiry compare, parameterised by `TIMEOUT`;
  - is instantiated only under `FPU_ISSUE_TIMEOUT_EN`.

## Test plan
- **Normal op:** accept unit 3, a=0x3F800000, b=0x40000000, c=0x01; FPU returns 0x40400000 three cycles after the strobe. Expect:
  - `fpu_in_valid`=0x008 for exactly one cycle;
  - `rsp_data`=0x40400000, `rsp_err`=0, `rsp_valid` one cycle after `fpu_out_valid`.
- **Bad unit:** `req_unit`=12 with NUM_UNITS=10. Expect no strobe, and `rsp_valid`=1 with `rsp_err`=1 and `rsp_data`=0 in the next cycle.
- **Back-pressure:** hold `rsp_ready`=0 for 5 cycles after the result. Expect `rsp_valid`/`rsp_data` stable, `req_ready`=0 throughout, and IDLE one cycle after `rsp_ready`.
- **Timeout (macro on, TIMEOUT=4):** no `fpu_out_valid`. Expect `rsp_err`=1 six cycles after accept, and a later `fpu_out_valid` to be ignored.
- **Simultaneous result and expiry:**
  - `fpu_out_valid` coincides with watchdog expiry → expect `rsp_err`=0 with the captured data.
  - `fpu_out_valid` pulsed while in IDLE → expect no response.
- **Reset mid-WAIT:** assert `rst_n`=0 asynchronously during WAIT. Expect all outputs at their reset values immediately; after release, a new operation completes normally.
